// File: rtl/ts_os_detector.sv
// Receive-side TS1/TS2/SKP ordered-set detector for one lane.
// Qualifies consecutive identical training sets and exposes the decoded fields of the last accepted TS.
module ts_os_detector #(
    parameter int CONSEC_REQ = 8,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_k,
    input  logic       symbol_lock,
    input  logic       clear,
    output logic       ts1_received,
    output logic       ts2_received,
    output logic       skp_received,
    output logic       os_error,
    output logic [7:0] rx_link_num,
    output logic [7:0] rx_lane_num,
    output logic       link_pad,
    output logic       lane_pad,
    output logic [7:0] rx_n_fts,
    output logic [7:0] rx_rate_id,
    output logic [7:0] rx_train_ctrl
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_TS_BODY = 2'd1;
    localparam logic [1:0] ST_SKP     = 2'd2;

    localparam logic [7:0] K_COM  = 8'hBC;
    localparam logic [7:0] K_PAD  = 8'hF7;
    localparam logic [7:0] K_SKP  = 8'h1C;
    localparam logic [7:0] ID_TS1 = 8'h4A;
    localparam logic [7:0] ID_TS2 = 8'h45;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONSEC_REQ);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] link;
        logic [7:0] lane;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;

    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [2:0]       skp_cnt_q, skp_cnt_d;
    ts_fields_t       cur_q, cur_d;
    logic             cur_ts2_q, cur_ts2_d;
    ts_fields_t       prev_q, prev_d;
    logic             prev_ts2_q, prev_ts2_d;
    logic             prev_valid_q, prev_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ts1_q, ts1_d;
    logic             ts2_q, ts2_d;
    logic             skp_pulse_q, skp_pulse_d;
    logic             os_error_q, os_error_d;
    ts_fields_t       fields_q, fields_d;

    logic             sym_com, sym_pad, sym_skp, sym_data, id_ok, same_set, viol;
    logic [CNT_W-1:0] cnt_inc;

    assign sym_com  = rx_k && (rx_data == K_COM);
    assign sym_pad  = rx_k && (rx_data == K_PAD);
    assign sym_skp  = rx_k && (rx_data == K_SKP);
    assign sym_data = !rx_k;
    assign id_ok    = sym_data && (rx_data == (cur_ts2_q ? ID_TS2 : ID_TS1));
    // PAD vs data 0x00 differ through the pad flags, so a whole-struct compare matches symbol equality.
    assign same_set = prev_valid_q && (prev_ts2_q == cur_ts2_q) && (prev_q == cur_q);
    assign cnt_inc  = same_set ? ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE) : CNT_ONE;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        skp_cnt_d    = skp_cnt_q;
        cur_d        = cur_q;
        cur_ts2_d    = cur_ts2_q;
        prev_d       = prev_q;
        prev_ts2_d   = prev_ts2_q;
        prev_valid_d = prev_valid_q;
        cnt_d        = cnt_q;
        ts1_d        = ts1_q;
        ts2_d        = ts2_q;
        skp_pulse_d  = 1'b0;
        os_error_d   = 1'b0;
        fields_d     = fields_q;
        viol         = 1'b0;

        if (!symbol_lock || clear) begin
            state_d      = ST_HUNT;
            cnt_d        = '0;
            ts1_d        = 1'b0;
            ts2_d        = 1'b0;
            prev_valid_d = 1'b0;
            prev_d       = '0;
            prev_ts2_d   = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sym_com) begin
                        state_d = ST_TS_BODY;
                        idx_d   = 4'd1;
                    end
                end
                ST_SKP: begin
                    // A symbol that ends the SKP run is handled exactly as in HUNT.
                    if (sym_skp && (skp_cnt_q < 3'd4)) begin
                        skp_cnt_d = skp_cnt_q + 3'd1;
                    end else if (sym_com) begin
                        state_d = ST_TS_BODY;
                        idx_d   = 4'd1;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_TS_BODY: begin
                    case (idx_q)
                        4'd1: begin
                            if (sym_skp) begin
                                state_d     = ST_SKP;
                                skp_cnt_d   = 3'd0;
                                skp_pulse_d = 1'b1;
                            end else if (sym_data) begin
                                cur_d.link     = rx_data;
                                cur_d.link_pad = 1'b0;
                            end else if (sym_pad) begin
                                cur_d.link     = 8'h00;
                                cur_d.link_pad = 1'b1;
                            end else begin
                                viol = 1'b1;
                            end
                        end
                        4'd2: begin
                            if (sym_data) begin
                                cur_d.lane     = rx_data;
                                cur_d.lane_pad = 1'b0;
                            end else if (sym_pad) begin
                                cur_d.lane     = 8'h00;
                                cur_d.lane_pad = 1'b1;
                            end else begin
                                viol = 1'b1;
                            end
                        end
                        4'd3: if (sym_data) cur_d.n_fts = rx_data; else viol = 1'b1;
                        4'd4: if (sym_data) cur_d.rate_id = rx_data; else viol = 1'b1;
                        4'd5: if (sym_data) cur_d.train_ctrl = rx_data; else viol = 1'b1;
                        4'd6: begin
                            if (sym_data && (rx_data == ID_TS1)) cur_ts2_d = 1'b0;
                            else if (sym_data && (rx_data == ID_TS2)) cur_ts2_d = 1'b1;
                            else viol = 1'b1;
                        end
                        default: if (!id_ok) viol = 1'b1;
                    endcase

                    if (viol) begin
                        os_error_d = 1'b1;
                        cnt_d      = '0;
                        idx_d      = 4'd1;
                        state_d    = sym_com ? ST_TS_BODY : ST_HUNT;
                    end else if (state_d == ST_TS_BODY) begin
                        if (idx_q == 4'd15) begin
                            cnt_d        = cnt_inc;
                            prev_d       = cur_q;
                            prev_ts2_d   = cur_ts2_q;
                            prev_valid_d = 1'b1;
                            fields_d     = cur_q;
                            state_d      = ST_HUNT;
                            if (cnt_inc == CNT_MAX) begin
                                if (cur_ts2_q) ts2_d = 1'b1;
                                else           ts1_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            idx_q        <= 4'd0;
            skp_cnt_q    <= 3'd0;
            cur_q        <= '0;
            cur_ts2_q    <= 1'b0;
            prev_q       <= '0;
            prev_ts2_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            cnt_q        <= '0;
            ts1_q        <= 1'b0;
            ts2_q        <= 1'b0;
            skp_pulse_q  <= 1'b0;
            os_error_q   <= 1'b0;
            fields_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            skp_cnt_q    <= skp_cnt_d;
            cur_q        <= cur_d;
            cur_ts2_q    <= cur_ts2_d;
            prev_q       <= prev_d;
            prev_ts2_q   <= prev_ts2_d;
            prev_valid_q <= prev_valid_d;
            cnt_q        <= cnt_d;
            ts1_q        <= ts1_d;
            ts2_q        <= ts2_d;
            skp_pulse_q  <= skp_pulse_d;
            os_error_q   <= os_error_d;
            fields_q     <= fields_d;
        end
    end

    assign ts1_received  = ts1_q;
    assign ts2_received  = ts2_q;
    assign skp_received  = skp_pulse_q;
    assign os_error      = os_error_q;
    assign rx_link_num   = fields_q.link;
    assign rx_lane_num   = fields_q.lane;
    assign link_pad      = fields_q.link_pad;
    assign lane_pad      = fields_q.lane_pad;
    assign rx_n_fts      = fields_q.n_fts;
    assign rx_rate_id    = fields_q.rate_id;
    assign rx_train_ctrl = fields_q.train_ctrl;

endmodule
